// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Number of entries addressed by an addr_w-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Low bit of slice idx in a flat vector of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port output select: write bypass, r0 zeroing and init masking.
module regfile_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        stored_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     busy,
    output logic [DATA_W-1:0]        rd_data_c
);
    import regfile_pkg::*;

    // Stored value, overridden by the highest-index hitting write port.
    always_comb begin
        rd_data_c = stored_data;
        if (BYPASS != 0) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[slice_lo(32'(j), ADDR_W) +: ADDR_W] == rd_addr)) begin
                    rd_data_c = wr_data[slice_lo(32'(j), DATA_W) +: DATA_W];
                end
            end
        end
        if (busy || (rd_addr == '0)) begin
            rd_data_c = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired r0, write bypass,
// post-reset clear sweep and a per-register pending scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     init_busy
);
    import regfile_pkg::*;

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                busy;
    logic                write_ok;

    assign init_busy = (state_q == CLEAR);
    assign busy      = rst || (state_q == CLEAR);
    assign write_ok  = !rst && (state_q == READY);

    // Clear sweep sequencing: one entry per cycle from 1 up to DEPTH-1.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Storage update: sweep clear, or port writes in ascending priority.
    always_comb begin
        mem_d = mem_q;
        if (!rst && (state_q == CLEAR)) begin
            mem_d[clr_idx_q] = '0;
        end
        if (write_ok) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[slice_lo(32'(j), ADDR_W) +: ADDR_W] != '0)) begin
                    mem_d[wr_addr[slice_lo(32'(j), ADDR_W) +: ADDR_W]] =
                        wr_data[slice_lo(32'(j), DATA_W) +: DATA_W];
                end
            end
        end
        mem_d[0] = '0;
    end

    // Scoreboard: committed writes clear, a new issue sets (set wins).
    always_comb begin
        pend_d = pend_q;
        if (write_ok) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j]) begin
                    pend_d[wr_addr[slice_lo(32'(j), ADDR_W) +: ADDR_W]] = 1'b0;
                end
            end
            if (pend_set) begin
                pend_d[pend_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Control state with synchronous reset restarting the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= ADDR_W'(1);
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
        end
    end

    // Data array; contents are cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read ports.
    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] addr_i;
        assign addr_i = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        regfile_fwd_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS)
        ) u_fwd_mux (
            .rd_addr     (addr_i),
            .stored_data (mem_q[addr_i]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .busy        (busy),
            .rd_data_c   (rd_data[slice_lo(i, DATA_W) +: DATA_W])
        );

        assign rd_pending[i] = !busy && pend_q[addr_i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass instances share stimulus.
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;

    logic [NUM_RD*DATA_W-1:0] rd_data_b1, rd_data_b0;
    logic [NUM_RD-1:0]        rd_pend_b1, rd_pend_b0;
    logic                     busy_b1, busy_b0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_pending(rd_pend_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .init_busy(busy_b1)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_pending(rd_pend_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .init_busy(busy_b0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: architectural contents, pending set, sweep cycles left.
    logic [31:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];
    int          m_busy_left = 0;
    bit          m_valid = 1'b0;

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) begin
            m_mem[a]  = 'x;
            m_pend[a] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left = DEPTH - 1;
            for (int a = 0; a < int'(DEPTH); a++) m_pend[a] = 1'b0;
            m_valid = 1'b1;
        end else if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = '0;
            m_busy_left--;
        end else begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] != 0) begin
                    m_mem[wr_addr[j*5 +: 5]]  = wr_data[j*32 +: 32];
                    m_pend[wr_addr[j*5 +: 5]] = 1'b0;
                end
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input int i, input bit byp);
        logic [4:0]  a;
        logic [31:0] v;
        a = rd_addr[i*5 +: 5];
        if (rst || m_busy_left > 0 || a == 0) return '0;
        v = m_mem[a];
        if (byp) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
            end
        end
        return v;
    endfunction

    function automatic bit exp_pend(input int i);
        logic [4:0] a;
        a = rd_addr[i*5 +: 5];
        if (rst || m_busy_left > 0) return 1'b0;
        return m_pend[a];
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("init_busy_b1", 32'(busy_b1), 32'(m_busy_left > 0));
            check("init_busy_b0", 32'(busy_b0), 32'(m_busy_left > 0));
            for (int i = 0; i < int'(NUM_RD); i++) begin
                check($sformatf("rd_data%0d_b1", i), rd_data_b1[i*32 +: 32], exp_rd(i, 1'b1));
                check($sformatf("rd_data%0d_b0", i), rd_data_b0[i*32 +: 32], exp_rd(i, 1'b0));
                check($sformatf("rd_pending%0d_b1", i), 32'(rd_pend_b1[i]), 32'(exp_pend(i)));
                check($sformatf("rd_pending%0d_b0", i), 32'(rd_pend_b0[i]), 32'(exp_pend(i)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle_inputs();
        tick();
        tick();

        // 1: release, with a write and pend_set attempted during the sweep
        rst       = 1'b0;
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd3};
        wr_data   = {32'd0, 32'd55};
        pend_set  = 1'b1;
        pend_addr = 5'd4;
        count_busy(n);
        check("sweep_len_first", 32'(n), 32'd31);
        idle_inputs();
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #3;
            check("swept_zero_p0", rd_data_b1[31:0], 32'd0);
            check("swept_zero_p1", rd_data_b1[63:32], 32'd0);
            check("swept_not_pending", 32'(rd_pend_b1), 32'd0);
            tick();
        end

        // 2: same-cycle bypass vs stored value
        rd_addr = {5'd0, 5'd5};
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'd0, 32'hDEADBEEF};
        #3;
        check("bypass_b1", rd_data_b1[31:0], 32'hDEADBEEF);
        check("nobypass_b0", rd_data_b0[31:0], 32'd0);
        tick();
        idle_inputs();
        #3;
        check("stored_b1", rd_data_b1[31:0], 32'hDEADBEEF);
        check("stored_b0", rd_data_b0[31:0], 32'hDEADBEEF);
        tick();

        // 3: two ports on one address, highest port wins
        rd_addr = {5'd0, 5'd7};
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h2, 32'h1};
        #3;
        check("dual_bypass_b1", rd_data_b1[31:0], 32'h2);
        check("dual_bypass_b0", rd_data_b0[31:0], 32'd0);
        tick();
        idle_inputs();
        #3;
        check("dual_stored", rd_data_b1[31:0], 32'h2);
        tick();

        // 4: r0 ignores writes and pend_set
        rd_addr   = {5'd0, 5'd0};
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd0};
        wr_data   = {32'd0, 32'hFFFFFFFF};
        pend_set  = 1'b1;
        pend_addr = 5'd0;
        #3;
        check("r0_bypass", rd_data_b1[31:0], 32'd0);
        tick();
        idle_inputs();
        #3;
        check("r0_stored", rd_data_b1[31:0], 32'd0);
        check("r0_pending", 32'(rd_pend_b1[0]), 32'd0);
        tick();

        // 5: scoreboard set, set-beats-clear, then clear
        rd_addr   = {5'd9, 5'd0};
        pend_set  = 1'b1;
        pend_addr = 5'd9;
        tick();
        idle_inputs();
        #3;
        check("pend_set", 32'(rd_pend_b1[1]), 32'd1);
        pend_set  = 1'b1;
        pend_addr = 5'd9;
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd9};
        wr_data   = {32'd0, 32'h99};
        tick();
        idle_inputs();
        #3;
        check("pend_set_wins", 32'(rd_pend_b1[1]), 32'd1);
        wr_en   = 2'b10;
        wr_addr = {5'd9, 5'd0};
        wr_data = {32'hAA, 32'd0};
        #3;
        check("pend_no_bypass", 32'(rd_pend_b1[1]), 32'd1);
        tick();
        idle_inputs();
        #3;
        check("pend_cleared", 32'(rd_pend_b1[1]), 32'd0);
        check("pend_write_data", rd_data_b1[63:32], 32'hAA);
        tick();

        // 6: reset mid-sweep restarts it; writes during sweep are dropped
        pend_set  = 1'b1;
        pend_addr = 5'd9;
        tick();
        idle_inputs();
        rst = 1'b1;
        #3;
        check("rst_masks_data", rd_data_b1[63:32], 32'd0);
        check("rst_masks_pend", 32'(rd_pend_b1[1]), 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'd0, 32'h1234};
        count_busy(n);
        check("sweep_len_restart", 32'(n), 32'd31);
        idle_inputs();
        rd_addr = {5'd9, 5'd5};
        #3;
        check("post_sweep_addr5", rd_data_b1[31:0], 32'd0);
        check("post_sweep_addr9", rd_data_b1[63:32], 32'd0);
        check("post_sweep_pend9", 32'(rd_pend_b1[1]), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
